fpu_result_writeback: RTL and testbench

- Downstream stage of the FP arithmetic units, including the square-root unit. It consumes a 64-bit result, a precision bit and the per-operation exception flags, and buffers them in a small FIFO.
- On the way in it NaN-boxes single-precision results and optionally canonicalises NaNs.
- At commit it presents results to the register-file write port with a valid/ready handshake and accumulates sticky exception flags (fflags).

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_wb_fifo.sv | 66 ++++++
 rtl/fpu_result_writeback.sv | 87 ++++++++
 tb/tb_fpu_result_writeback.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP result writeback path.
// Flag bit positions, canonical NaN encodings and the buffered entry layout.
package fpu_pkg;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam logic [63:0] CANON_NAN_DP = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] CANON_NAN_SP = 32'h7FC0_0000;

    localparam int WB_TAG_W = 5;

    typedef struct packed {
        logic [63:0]         result;
        logic [4:0]          flags;
        logic [WB_TAG_W-1:0] tag;
    } fp_wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Synchronous DEPTH-entry FIFO of writeback entries with flush.
// A push is refused when full even if a pop happens in the same cycle.
module fpu_wb_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fp_wb_entry_t i_wdata,
    output fp_wb_entry_t o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fp_wb_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointers are log2(DEPTH) wide so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_result_writeback.sv
// FP result writeback: NaN-box/canonicalise on entry, buffer, commit with
// valid/ready and accumulate sticky fflags from committed entries.
module fpu_result_writeback
    import fpu_pkg::*;
#(
    parameter int TAG_W     = 5,
    parameter int DEPTH     = 2,
    parameter bit CANON_NAN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_result,
    input  logic             in_is_dp,
    input  logic [4:0]       in_flags,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_flags,
    input  logic             csr_we,
    input  logic [4:0]       csr_wdata,
    output logic [4:0]       fflags
);

    function automatic logic [63:0] box_result(input logic [63:0] res, input logic is_dp);
        logic        dp_nan;
        logic        sp_nan;
        logic [31:0] sp;
        dp_nan = (res[62:52] == 11'h7FF) && (res[51:0] != '0);
        sp_nan = (res[30:23] == 8'hFF) && (res[22:0] != '0);
        if (is_dp) begin
            return (CANON_NAN && dp_nan) ? CANON_NAN_DP : res;
        end
        sp = (CANON_NAN && sp_nan) ? CANON_NAN_SP : res[31:0];
        return {32'hFFFF_FFFF, sp};
    endfunction

    fp_wb_entry_t            w_in_entry;
    fp_wb_entry_t            w_head;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [4:0]              r_fflags;

    assign w_in_entry.result = box_result(in_result, in_is_dp);
    assign w_in_entry.flags  = in_flags;
    assign w_in_entry.tag    = in_tag;

    assign in_ready  = ~w_full;
    assign out_valid = (w_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_ready & ~w_empty;

    fpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_wdata (w_in_entry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_result = w_head.result;
    assign out_tag    = w_head.tag;
    assign out_flags  = w_head.flags;
    assign fflags     = r_fflags;

    // A commit coinciding with a flush or CSR write still contributes its flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fflags <= '0;
        end else begin
            r_fflags <= (csr_we ? csr_wdata : r_fflags) | (w_pop ? w_head.flags : 5'b0);
        end
    end

endmodule

// File: tb/tb_fpu_result_writeback.sv
// Bench for fpu_result_writeback: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_fpu_result_writeback;

    localparam int DEPTH = 2;
    localparam bit CANON = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_is_dp;
    logic [4:0]  in_flags;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic [4:0]  out_flags;
    logic        csr_we;
    logic [4:0]  csr_wdata;
    logic [4:0]  fflags;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  fl;
        logic [4:0]  tg;
    } ref_t;

    ref_t       m_q[$];
    logic [4:0] m_ff;

    always #5 clk = ~clk;

    fpu_result_writeback #(.TAG_W(5), .DEPTH(DEPTH), .CANON_NAN(CANON)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_is_dp   (in_is_dp),
        .in_flags   (in_flags),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .fflags     (fflags)
    );

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference transform from IEEE field definitions.
    function automatic logic [63:0] ref_box(input logic [63:0] r, input logic dp);
        longint unsigned exp_dp, frac_dp, exp_sp, frac_sp;
        exp_dp  = (r >> 52) & 64'h7FF;
        frac_dp = r & ((64'd1 << 52) - 1);
        exp_sp  = (r >> 23) & 64'hFF;
        frac_sp = r & ((64'd1 << 23) - 1);
        if (dp) begin
            if (CANON && exp_dp == 64'h7FF && frac_dp != 0) return 64'h7FF8_0000_0000_0000;
            return r;
        end
        if (CANON && exp_sp == 64'hFF && frac_sp != 0) return 64'hFFFF_FFFF_7FC0_0000;
        return 64'hFFFF_FFFF_0000_0000 | (r & 64'hFFFF_FFFF);
    endfunction

    // Compare current outputs with the model, then advance model and DUT one edge.
    task automatic tick();
        bit   m_pop, m_push;
        ref_t e;
        logic [4:0] nf;
        check_val("in_ready",  {63'd0, in_ready},  {63'd0, m_q.size() < DEPTH});
        check_val("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() != 0});
        check_val("fflags",    {59'd0, fflags},    {59'd0, m_ff});
        if (m_q.size() != 0) begin
            check_val("out_result", out_result, m_q[0].res);
            check_val("out_tag",    {59'd0, out_tag},   {59'd0, m_q[0].tg});
            check_val("out_flags",  {59'd0, out_flags}, {59'd0, m_q[0].fl});
        end
        m_pop  = (m_q.size() != 0) && out_ready;
        m_push = in_valid && (m_q.size() < DEPTH);
        if (rst) begin
            m_q.delete();
            m_ff = '0;
        end else begin
            nf = (csr_we ? csr_wdata : m_ff) | (m_pop ? m_q[0].fl : 5'd0);
            if (m_pop) void'(m_q.pop_front());
            if (flush) m_q.delete();
            else if (m_push) begin
                e.res = ref_box(in_result, in_is_dp);
                e.fl  = in_flags;
                e.tg  = in_tag;
                m_q.push_back(e);
            end
            m_ff = nf;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_in(input logic v, input logic dp, input logic [63:0] r,
                            input logic [4:0] f, input logic [4:0] t);
        in_valid  = v;
        in_is_dp  = dp;
        in_result = r;
        in_flags  = f;
        in_tag    = t;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; csr_we = 1'b0; csr_wdata = '0;
        drive_in(1'b0, 1'b0, 64'd0, 5'd0, 5'd0);
        m_ff = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_out_result", out_result, 64'd0);
        check_val("rst_out_tag",    {59'd0, out_tag},   64'd0);
        check_val("rst_out_flags",  {59'd0, out_flags}, 64'd0);

        // 1: DP 2.0 appears one cycle after push
        out_ready = 1'b1;
        drive_in(1'b1, 1'b1, 64'h4000_0000_0000_0000, 5'd0, 5'd3);
        check_val("t1_not_yet", {63'd0, out_valid}, 64'd0);
        tick();
        drive_in(1'b0, 1'b0, 64'd0, 5'd0, 5'd0);
        check_val("t1_valid",  {63'd0, out_valid}, 64'd1);
        check_val("t1_result", out_result, 64'h4000_0000_0000_0000);
        check_val("t1_tag",    {59'd0, out_tag}, 64'd3);
        tick();
        check_val("t1_fflags", {59'd0, fflags}, 64'd0);

        // 2: SP boxing, flags only after commit
        out_ready = 1'b0;
        drive_in(1'b1, 1'b0, 64'hDEAD_BEEF_3FB5_04F3, 5'b00001, 5'd4);
        tick();
        drive_in(1'b0, 1'b0, 64'd0, 5'd0, 5'd0);
        check_val("t2_result", out_result, 64'hFFFF_FFFF_3FB5_04F3);
        check_val("t2_ff_pre", {59'd0, fflags}, 64'd0);
        out_ready = 1'b1;
        tick();
        check_val("t2_ff_post", {59'd0, fflags}, 64'd1);

        // 3: NaN canonicalisation SP then DP
        out_ready = 1'b0;
        drive_in(1'b1, 1'b0, 64'h0000_0000_7F80_0001, 5'b10000, 5'd5);
        tick();
        check_val("t3_sp_nan", out_result, 64'hFFFF_FFFF_7FC0_0000);
        out_ready = 1'b1;
        drive_in(1'b1, 1'b1, 64'hFFF0_0000_0000_0001, 5'd0, 5'd6);
        tick();
        drive_in(1'b0, 1'b0, 64'd0, 5'd0, 5'd0);
        check_val("t3_nv", {63'd0, fflags[4]}, 64'd1);
        check_val("t3_dp_nan", out_result, 64'h7FF8_0000_0000_0000);
        tick();

        // 4: backpressure with DEPTH entries, ordered drain
        out_ready = 1'b0;
        drive_in(1'b1, 1'b1, 64'h1, 5'd0, 5'd0);
        tick();
        drive_in(1'b1, 1'b1, 64'h2, 5'd0, 5'd1);
        tick();
        drive_in(1'b1, 1'b1, 64'h3, 5'd0, 5'd2);
        check_val("t4_full", {63'd0, in_ready}, 64'd0);
        tick();
        tick();
        out_ready = 1'b1;
        check_val("t4_tag0", {59'd0, out_tag}, 64'd0);
        tick();
        check_val("t4_tag1", {59'd0, out_tag}, 64'd1);
        tick();
        drive_in(1'b0, 1'b0, 64'd0, 5'd0, 5'd0);
        check_val("t4_tag2", {59'd0, out_tag}, 64'd2);
        tick();

        // 5: CSR write coinciding with commit
        out_ready = 1'b0;
        drive_in(1'b1, 1'b1, 64'h5, 5'b00100, 5'd7);
        tick();
        drive_in(1'b0, 1'b0, 64'd0, 5'd0, 5'd0);
        out_ready = 1'b1; csr_we = 1'b1; csr_wdata = 5'b00010;
        tick();
        check_val("t5_merge", {59'd0, fflags}, 64'b00110);
        out_ready = 1'b0; csr_wdata = 5'b00000;
        tick();
        csr_we = 1'b0;
        check_val("t5_clear", {59'd0, fflags}, 64'd0);

        // 6: flush with push and pop, then reset mid-stream
        drive_in(1'b1, 1'b1, 64'h10, 5'b01000, 5'd8);
        tick();
        drive_in(1'b1, 1'b1, 64'h11, 5'b00001, 5'd9);
        tick();
        drive_in(1'b1, 1'b1, 64'h12, 5'b00000, 5'd10);
        flush = 1'b1; out_ready = 1'b1;
        check_val("t6_full", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b0;
        drive_in(1'b0, 1'b0, 64'd0, 5'd0, 5'd0);
        check_val("t6_ovalid", {63'd0, out_valid}, 64'd0);
        check_val("t6_iready", {63'd0, in_ready}, 64'd1);
        check_val("t6_ff",     {59'd0, fflags}, 64'b01000);
        tick();
        out_ready = 1'b0;
        drive_in(1'b1, 1'b0, 64'h3F80_0000, 5'b00011, 5'd11);
        tick();
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        drive_in(1'b0, 1'b0, 64'd0, 5'd0, 5'd0);
        check_val("t6_rst_ff", {59'd0, fflags}, 64'd0);
        check_val("t6_rst_ov", {63'd0, out_valid}, 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] r;
            int sel;
            sel = $urandom_range(0, 5);
            r = {$urandom, $urandom};
            if (sel == 0) r[62:52] = 11'h7FF;
            if (sel == 1) r[30:23] = 8'hFF;
            if (sel == 2) begin r[62:52] = 11'h7FF; r[51:0] = '0; end
            drive_in(1'($urandom_range(0, 3) != 0), 1'($urandom), r,
                     5'($urandom), 5'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            csr_we    = ($urandom_range(0, 20) == 0);
            csr_wdata = 5'($urandom);
            rst       = ($urandom_range(0, 200) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
